// File: rtl/touch_spi_ctrl.sv
// touch_spi_ctrl: polls a TSC2046-class touch ADC over SPI once per sample
// period and publishes registered X/Y/Z1 samples gated by the pen interrupt.
module touch_spi_ctrl #(
    parameter int          CLK_DIV       = 25,
    parameter int          SAMPLE_PERIOD = 500000,
    parameter logic [11:0] Z_THRESHOLD   = 12'd100
) (
    input  logic        cclk,
    input  logic        rstb,
    input  logic        enable,
    input  logic        pen_irq_n,
    input  logic        spi_miso,
    output logic        spi_mosi,
    output logic        spi_sclk,
    output logic        spi_cs_n,
    output logic [11:0] touch_x,
    output logic [11:0] touch_y,
    output logic [11:0] touch_z,
    output logic        touched,
    output logic        sample_valid,
    output logic        busy
);

    localparam int DW = $clog2(CLK_DIV);
    localparam int TW = $clog2(SAMPLE_PERIOD);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CS_SETUP,
        S_SHIFT,
        S_CS_HOLD,
        S_UPDATE
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [DW-1:0] r_div;
    logic [DW-1:0] w_div_nxt;
    logic          r_phase;
    logic          w_phase_nxt;
    logic [4:0]    r_bit;
    logic [4:0]    w_bit_nxt;
    logic [1:0]    r_chan;
    logic [1:0]    w_chan_nxt;
    logic [TW-1:0] r_tick;
    logic          r_pen_s1;
    logic          r_pen_s2;
    logic [10:0]   r_sr;
    logic [11:0]   r_shadow_x;
    logic [11:0]   r_shadow_y;
    logic [11:0]   r_shadow_z;

    logic          w_tick;
    logic          w_div_end;
    logic          w_nopen;
    logic          w_update;
    logic          w_capture;
    logic [7:0]    w_cmd;
    logic [2:0]    w_cmd_idx;
    logic          w_mosi_nxt;

    logic          r_mosi;
    logic          r_sclk;
    logic          r_cs_n;
    logic [11:0]   r_x;
    logic [11:0]   r_y;
    logic [11:0]   r_z;
    logic          r_touched;
    logic          r_valid;
    logic          r_busy;

    assign w_tick    = (r_tick == TICK_LAST);
    assign w_div_end = (r_div == DIV_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div;
        w_phase_nxt = r_phase;
        w_bit_nxt   = r_bit;
        w_chan_nxt  = r_chan;
        w_nopen     = 1'b0;
        w_update    = 1'b0;
        w_capture   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_tick && enable) begin
                    if (!r_pen_s2) begin
                        w_state_nxt = S_CS_SETUP;
                        w_div_nxt   = '0;
                        w_chan_nxt  = 2'd0;
                    end else begin
                        w_nopen = 1'b1;
                    end
                end
            end
            S_CS_SETUP: begin
                if (w_div_end) begin
                    w_state_nxt = S_SHIFT;
                    w_div_nxt   = '0;
                    w_phase_nxt = 1'b0;
                    w_bit_nxt   = 5'd0;
                end else begin
                    w_div_nxt = r_div + DW'(1);
                end
            end
            S_SHIFT: begin
                if (!w_div_end) begin
                    w_div_nxt = r_div + DW'(1);
                end else begin
                    w_div_nxt = '0;
                    if (!r_phase) begin
                        w_phase_nxt = 1'b1;
                    end else begin
                        // last cclk of the high phase: MISO is stable here
                        w_capture   = 1'b1;
                        w_phase_nxt = 1'b0;
                        if (r_bit == 5'd23) begin
                            w_state_nxt = S_CS_HOLD;
                        end else begin
                            w_bit_nxt = r_bit + 5'd1;
                        end
                    end
                end
            end
            S_CS_HOLD: begin
                if (w_div_end) begin
                    w_div_nxt = '0;
                    if (r_chan == 2'd2) begin
                        w_state_nxt = S_UPDATE;
                        w_update    = 1'b1;
                    end else begin
                        w_chan_nxt  = r_chan + 2'd1;
                        w_state_nxt = S_CS_SETUP;
                    end
                end else begin
                    w_div_nxt = r_div + DW'(1);
                end
            end
            S_UPDATE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        unique case (w_chan_nxt)
            2'd0:    w_cmd = 8'hD0;
            2'd1:    w_cmd = 8'h90;
            default: w_cmd = 8'hB0;
        endcase
        w_cmd_idx  = 3'd7 - w_bit_nxt[2:0];
        w_mosi_nxt = 1'b0;
        if (w_state_nxt == S_CS_SETUP) begin
            w_mosi_nxt = w_cmd[7];
        end else if (w_state_nxt == S_SHIFT && w_bit_nxt < 5'd8) begin
            w_mosi_nxt = w_cmd[w_cmd_idx];
        end
    end

    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_phase <= 1'b0;
            r_bit   <= 5'd0;
            r_chan  <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_div   <= w_div_nxt;
            r_phase <= w_phase_nxt;
            r_bit   <= w_bit_nxt;
            r_chan  <= w_chan_nxt;
        end
    end

    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            r_tick   <= '0;
            r_pen_s1 <= 1'b1;
            r_pen_s2 <= 1'b1;
        end else begin
            r_tick   <= w_tick ? '0 : r_tick + TW'(1);
            r_pen_s1 <= pen_irq_n;
            r_pen_s2 <= r_pen_s1;
        end
    end

    // result bits arrive on k=9..20; the shadow is written on the LSB
    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            r_sr       <= '0;
            r_shadow_x <= '0;
            r_shadow_y <= '0;
            r_shadow_z <= '0;
        end else if (w_capture && r_bit >= 5'd9 && r_bit <= 5'd20) begin
            r_sr <= {r_sr[9:0], spi_miso};
            if (r_bit == 5'd20) begin
                unique case (r_chan)
                    2'd0:    r_shadow_x <= {r_sr, spi_miso};
                    2'd1:    r_shadow_y <= {r_sr, spi_miso};
                    default: r_shadow_z <= {r_sr, spi_miso};
                endcase
            end
        end
    end

    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            r_mosi    <= 1'b0;
            r_sclk    <= 1'b0;
            r_cs_n    <= 1'b1;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
            r_z       <= '0;
            r_touched <= 1'b0;
        end else begin
            r_mosi  <= w_mosi_nxt;
            r_sclk  <= (w_state_nxt == S_SHIFT) && w_phase_nxt;
            r_cs_n  <= !((w_state_nxt == S_CS_SETUP) ||
                         (w_state_nxt == S_SHIFT));
            r_busy  <= (w_state_nxt != S_IDLE);
            r_valid <= w_update || w_nopen;
            if (w_nopen) begin
                r_z       <= '0;
                r_touched <= 1'b0;
            end else if (w_update) begin
                r_z <= r_shadow_z;
                if (r_shadow_z >= Z_THRESHOLD) begin
                    r_touched <= 1'b1;
                    r_x       <= r_shadow_x;
                    r_y       <= r_shadow_y;
                end else begin
                    r_touched <= 1'b0;
                end
            end
        end
    end

    assign spi_mosi     = r_mosi;
    assign spi_sclk     = r_sclk;
    assign spi_cs_n     = r_cs_n;
    assign touch_x      = r_x;
    assign touch_y      = r_y;
    assign touch_z      = r_z;
    assign touched      = r_touched;
    assign sample_valid = r_valid;
    assign busy         = r_busy;

endmodule

// File: tb/tb_touch_spi_ctrl.sv
// Bench for touch_spi_ctrl: ADC model on the SPI pins, a sample-level
// reference model, and a second short-period instance for dropped ticks.
module tb_touch_spi_ctrl;

    localparam int          CD    = 3;
    localparam int          SP    = 600;
    localparam int          SP_B  = 300;
    localparam logic [11:0] TH    = 12'd100;
    localparam int          BURST = 3 * 50 * CD + 1;
    localparam int          WIN_B = 3000;

    logic        cclk = 1'b0;
    logic        rstb = 1'b0;
    logic        enable = 1'b0;
    logic        pen_irq_n = 1'b0;
    logic        spi_miso = 1'b0;
    logic        spi_mosi, spi_sclk, spi_cs_n;
    logic [11:0] touch_x, touch_y, touch_z;
    logic        touched, sample_valid, busy;

    logic        rstb_b = 1'b0;
    logic        enable_b = 1'b0;
    logic        pen_b = 1'b0;
    logic        miso_b = 1'b0;
    logic        mosi_b, sclk_b, cs_n_b;
    logic [11:0] x_b, y_b, z_b;
    logic        touched_b, valid_b, busy_b;

    always #5 cclk = ~cclk;

    touch_spi_ctrl #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP), .Z_THRESHOLD(TH)) dut (
        .cclk(cclk), .rstb(rstb), .enable(enable), .pen_irq_n(pen_irq_n),
        .spi_miso(spi_miso), .spi_mosi(spi_mosi), .spi_sclk(spi_sclk),
        .spi_cs_n(spi_cs_n), .touch_x(touch_x), .touch_y(touch_y),
        .touch_z(touch_z), .touched(touched), .sample_valid(sample_valid),
        .busy(busy)
    );

    touch_spi_ctrl #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP_B), .Z_THRESHOLD(TH)) dut_b (
        .cclk(cclk), .rstb(rstb_b), .enable(enable_b), .pen_irq_n(pen_b),
        .spi_miso(miso_b), .spi_mosi(mosi_b), .spi_sclk(sclk_b),
        .spi_cs_n(cs_n_b), .touch_x(x_b), .touch_y(y_b),
        .touch_z(z_b), .touched(touched_b), .sample_valid(valid_b),
        .busy(busy_b)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit          nopen;
        logic [11:0] x;
        logic [11:0] y;
        logic [11:0] z;
    } ev_t;

    typedef struct {
        logic [7:0] cmd;
        int         edges;
        bit         extra;
    } win_t;

    ev_t         evq[$];
    win_t        wq[$];
    logic [11:0] m_x = '0, m_y = '0, m_z = '0;
    logic        m_t = 1'b0;
    logic [11:0] adc_x = '0, adc_y = '0, adc_z = '0;

    // ADC model: shift out busy bit, 12 result bits MSB first, noise elsewhere
    function automatic logic adc_bit(input int k, input logic [7:0] c);
        logic [11:0] v;
        v = (c == 8'hD0) ? adc_x : (c == 8'h90) ? adc_y : adc_z;
        if (k >= 9 && k <= 20) return v[4'(20 - k)];
        if (k == 8) return 1'b0;
        return 1'($urandom);
    endfunction

    logic       prev_cs = 1'b1;
    logic       prev_sclk = 1'b0;
    bit         in_win = 0;
    int         mon_k = 0;
    logic [7:0] mon_cmd = '0;
    bit         mon_extra = 0;

    always @(negedge cclk) begin
        if (!rstb) begin
            in_win = 0;
            mon_k  = 0;
        end else begin
            if (prev_cs && !spi_cs_n) begin
                in_win    = 1;
                mon_k     = 0;
                mon_cmd   = '0;
                mon_extra = 0;
            end
            if (in_win && !prev_sclk && spi_sclk) begin
                if (mon_k < 8) mon_cmd = {mon_cmd[6:0], spi_mosi};
                else if (spi_mosi) mon_extra = 1;
                spi_miso = adc_bit(mon_k, mon_cmd);
                mon_k++;
            end
            if (in_win && spi_cs_n) begin
                wq.push_back('{mon_cmd, mon_k, mon_extra});
                in_win = 0;
            end
        end
        prev_cs   = spi_cs_n;
        prev_sclk = spi_sclk;
    end

    int  busy_len = 0;
    bit  prev_valid = 0;
    int  nvalid = 0;
    ev_t cev;

    always @(negedge cclk) begin
        if (rstb) begin
            if (sample_valid) begin
                nvalid++;
                if (prev_valid) chk("valid_width", 32'd2, 32'd1);
                if (evq.size() == 0) begin
                    chk("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    cev = evq.pop_front();
                    if (cev.nopen) begin
                        m_z = '0;
                        m_t = 1'b0;
                    end else begin
                        m_z = cev.z;
                        m_t = (cev.z >= TH);
                        if (cev.z >= TH) begin
                            m_x = cev.x;
                            m_y = cev.y;
                        end
                    end
                end
            end
            if (busy) begin
                busy_len++;
            end else begin
                if (busy_len != 0) chk("burst_len", 32'(busy_len), 32'(BURST));
                busy_len = 0;
                chk("idle_cs_sclk", {30'd0, spi_cs_n, spi_sclk}, 32'd2);
            end
        end else begin
            busy_len = 0;
            chk("rst_cs_sclk", {30'd0, spi_cs_n, spi_sclk}, 32'd2);
        end
        chk("touch_x", 32'(touch_x), 32'(m_x));
        chk("touch_y", 32'(touch_y), 32'(m_y));
        chk("touch_z", 32'(touch_z), 32'(m_z));
        chk("touched", 32'(touched), 32'(m_t));
        prev_valid = sample_valid;
    end

    task automatic do_sample(input bit pen_up, input logic [11:0] x,
                             input logic [11:0] y, input logic [11:0] z);
        ev_t  e;
        int   n;
        win_t w;
        logic [7:0] cmds [3];
        cmds = '{8'hD0, 8'h90, 8'hB0};
        adc_x = x;
        adc_y = y;
        adc_z = z;
        pen_irq_n = pen_up;
        e.nopen = pen_up;
        e.x = x;
        e.y = y;
        e.z = z;
        evq.push_back(e);
        wq.delete();
        n = 0;
        while (!sample_valid && n < 2 * SP + BURST) begin
            @(negedge cclk);
            n++;
        end
        if (!sample_valid) begin
            chk("valid_timeout", 32'd0, 32'd1);
            evq.delete();
        end
        repeat (3) @(negedge cclk);
        if (pen_up) begin
            chk("nopen_windows", 32'(wq.size()), 32'd0);
        end else begin
            chk("cs_windows", 32'(wq.size()), 32'd3);
            if (wq.size() == 3) begin
                for (int i = 0; i < 3; i++) begin
                    w = wq[i];
                    chk("mosi_cmd", 32'(w.cmd), 32'(cmds[i]));
                    chk("sclk_edges", 32'(w.edges), 32'd24);
                    chk("mosi_tail", 32'(w.extra), 32'd0);
                end
            end
        end
        wq.delete();
    endtask

    initial begin
        int  n;
        bit  found;
        int  free_t;
        int  exp_b;
        int  cnt_b;
        logic [11:0] rz;

        // reset and idle with the pen down but polling disabled
        repeat (10) @(negedge cclk);
        rstb = 1'b1;
        repeat (3 * SP) @(negedge cclk);
        chk("idle_cs_n", 32'(spi_cs_n), 32'd1);
        chk("idle_sclk", 32'(spi_sclk), 32'd0);
        chk("idle_mosi", 32'(spi_mosi), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_windows", 32'(wq.size()), 32'd0);
        chk("idle_valids", 32'(nvalid), 32'd0);

        enable = 1'b1;
        do_sample(1'b0, 12'hABC, 12'h123, 12'h200);
        chk("lit_x", 32'(touch_x), 32'hABC);
        chk("lit_y", 32'(touch_y), 32'h123);
        chk("lit_z", 32'(touch_z), 32'h200);
        chk("lit_t", 32'(touched), 32'd1);
        chk("lit_nvalid", 32'(nvalid), 32'd1);

        do_sample(1'b0, 12'h111, 12'h222, TH);
        chk("thr_eq_t", 32'(touched), 32'd1);
        chk("thr_eq_x", 32'(touch_x), 32'h111);

        do_sample(1'b0, 12'h333, 12'h444, TH - 12'd1);
        chk("thr_lo_t", 32'(touched), 32'd0);
        chk("thr_lo_x", 32'(touch_x), 32'h111);
        chk("thr_lo_y", 32'(touch_y), 32'h222);
        chk("thr_lo_z", 32'(touch_z), 32'(TH - 12'd1));

        do_sample(1'b1, 12'h777, 12'h888, 12'hFFF);
        chk("nopen_t", 32'(touched), 32'd0);
        chk("nopen_z", 32'(touch_z), 32'd0);
        chk("nopen_x", 32'(touch_x), 32'h111);

        for (int i = 0; i < 16; i++) begin
            case ($urandom % 3)
                0: rz = TH - 12'd1 + 12'($urandom % 3);
                1: rz = 12'($urandom % 200);
                default: rz = 12'($urandom);
            endcase
            do_sample(($urandom % 5) == 0, 12'($urandom), 12'($urandom), rz);
        end

        // reset in the middle of SHIFT, bit 12 of the X frame
        adc_x = 12'h5A5;
        pen_irq_n = 1'b0;
        found = 0;
        n = 0;
        while (!found && n < 2 * SP + BURST) begin
            @(negedge cclk);
            #1;
            if (in_win && mon_k == 13) found = 1;
            n++;
        end
        chk("reach_k12", 32'(found), 32'd1);
        chk("k12_sclk_high", 32'(spi_sclk), 32'd1);
        rstb = 1'b0;
        m_x = '0;
        m_y = '0;
        m_z = '0;
        m_t = 1'b0;
        #1;
        chk("async_cs_n", 32'(spi_cs_n), 32'd1);
        chk("async_sclk", 32'(spi_sclk), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        repeat (5) @(negedge cclk);
        rstb = 1'b1;
        wq.delete();
        evq.delete();
        do_sample(1'b0, 12'h5A5, 12'hA5A, 12'hFFF);
        chk("post_rst_x", 32'(touch_x), 32'h5A5);
        chk("post_rst_y", 32'(touch_y), 32'hA5A);
        chk("post_rst_z", 32'(touch_z), 32'hFFF);

        // disable: no bursts on dut while the short-period instance runs
        enable = 1'b0;
        wq.delete();
        n = nvalid;
        enable_b = 1'b1;
        rstb_b = 1'b1;
        cnt_b = 0;
        for (int c = 0; c < WIN_B; c++) begin
            @(negedge cclk);
            if (valid_b) cnt_b++;
        end
        free_t = 0;
        exp_b = 0;
        for (int t = SP_B; t < WIN_B; t += SP_B) begin
            if (t >= free_t) begin
                free_t = t + BURST;
                if (t + BURST < WIN_B - 10) exp_b++;
            end
        end
        chk("dropped_tick_bursts", 32'(cnt_b), 32'(exp_b));
        chk("disabled_valids", 32'(nvalid - n), 32'd0);
        chk("disabled_windows", 32'(wq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
